// File: rtl/mem_ring_arbiter_pkg.sv
// Shared types for the ring-buffer memory arbiter: FSM states, client id and client count.
package mem_arb_pkg;

    localparam int ARB_CLIENTS = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_DONE
    } arb_state_t;

    typedef logic [1:0] client_id_t;

    function automatic logic [ARB_CLIENTS-1:0] client_onehot(input client_id_t id);
        logic [ARB_CLIENTS-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mem_ring_arbiter_pick.sv
// Combinational round-robin picker: first requester found scanning last+1, last+2, ... (mod 4).
module rr_pick4
    import mem_arb_pkg::*;
(
    input  logic [ARB_CLIENTS-1:0] req,
    input  client_id_t             last,
    output logic                   valid,
    output client_id_t             id
);

    client_id_t cand;

    // Scan from farthest to nearest so the closest requester after 'last' wins.
    always_comb begin
        valid = 1'b0;
        id    = last;
        cand  = last;
        for (int k = ARB_CLIENTS; k >= 1; k--) begin
            cand = last + client_id_t'(k);
            if (req[cand]) begin
                valid = 1'b1;
                id    = cand;
            end
        end
    end

endmodule

// File: rtl/mem_ring_arbiter.sv
// Round-robin arbiter sharing one memory port among four ring-buffer clients.
// Optional MEM_ARB_TIMEOUT_EN: abort an access with cli_err after TIMEOUT cycles without mem_ack.
module mem_ring_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 255
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ARB_CLIENTS-1:0]        cli_req,
    input  logic [ARB_CLIENTS-1:0]        cli_we,
    input  logic [ARB_CLIENTS*ADDR_W-1:0] cli_addr,
    input  logic [ARB_CLIENTS*DATA_W-1:0] cli_wdata,
    output logic [ARB_CLIENTS-1:0]        cli_ack,
    output logic [ARB_CLIENTS-1:0]        cli_err,
    output logic [DATA_W-1:0]             cli_rdata,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    input  logic                          mem_ack,
    output client_id_t                    grant_id,
    output logic                          busy
);

    arb_state_t state, next_state;
    client_id_t last;
    logic       pick_valid;
    client_id_t pick_id;

    logic [ADDR_W-1:0] addr_arr  [ARB_CLIENTS];
    logic [DATA_W-1:0] wdata_arr [ARB_CLIENTS];

    for (genvar i = 0; i < ARB_CLIENTS; i++) begin : g_unpack
        assign addr_arr[i]  = cli_addr[i*ADDR_W +: ADDR_W];
        assign wdata_arr[i] = cli_wdata[i*DATA_W +: DATA_W];
    end

    rr_pick4 u_pick (
        .req   (cli_req),
        .last  (last),
        .valid (pick_valid),
        .id    (pick_id)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] to_cnt;
    logic             timed_out;
    logic             to_expire;

    assign to_expire = (to_cnt == TO_LAST);
`endif

    always_comb begin
        next_state = state;
        unique case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    next_state = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (mem_ack) begin
                    next_state = ARB_DONE;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (to_expire) begin
                    next_state = ARB_DONE;
                end
`endif
            end
            ARB_DONE: next_state = ARB_IDLE;
            default:  next_state = ARB_IDLE;
        endcase
    end

    assign mem_req = (state == ARB_BUSY);
    assign busy    = (state != ARB_IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
    assign cli_ack = (state == ARB_DONE && !timed_out) ? client_onehot(grant_id) : '0;
    assign cli_err = (state == ARB_DONE &&  timed_out) ? client_onehot(grant_id) : '0;
`else
    assign cli_ack = (state == ARB_DONE) ? client_onehot(grant_id) : '0;
    assign cli_err = '0;
`endif

    // Request fields are latched at grant so the memory side stays stable even if the client changes its inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            last      <= client_id_t'(ARB_CLIENTS - 1);
            grant_id  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cli_rdata <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            to_cnt    <= '0;
            timed_out <= 1'b0;
`endif
        end else begin
            state <= next_state;
            unique case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        grant_id  <= pick_id;
                        mem_we    <= cli_we[pick_id];
                        mem_addr  <= addr_arr[pick_id];
                        mem_wdata <= wdata_arr[pick_id];
`ifdef MEM_ARB_TIMEOUT_EN
                        to_cnt    <= '0;
                        timed_out <= 1'b0;
`endif
                    end
                end
                ARB_BUSY: begin
                    if (mem_ack && !mem_we) begin
                        cli_rdata <= mem_rdata;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    if (!mem_ack) begin
                        to_cnt <= to_cnt + 1'b1;
                        if (to_expire) begin
                            timed_out <= 1'b1;
                        end
                    end
`endif
                end
                ARB_DONE: last <= grant_id;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ring_arbiter.sv
// Directed self-checking bench for mem_ring_arbiter; timeout scenario built with MEM_ARB_TIMEOUT_EN.
module tb_mem_ring_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  cli_req = '0;
    logic [3:0]  cli_we = '0;
    logic [63:0] cli_addr = '0;
    logic [63:0] cli_wdata = '0;
    logic [3:0]  cli_ack;
    logic [3:0]  cli_err;
    logic [15:0] cli_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    client_id_t  grant_id;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem_model [logic [15:0]];

    mem_ring_arbiter #(
        .ADDR_W (16),
        .DATA_W (16)
`ifdef MEM_ARB_TIMEOUT_EN
        ,
        .TIMEOUT (8)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cli_req   (cli_req),
        .cli_we    (cli_we),
        .cli_addr  (cli_addr),
        .cli_wdata (cli_wdata),
        .cli_ack   (cli_ack),
        .cli_err   (cli_err),
        .cli_rdata (cli_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_client(input int i, input logic we, input logic [15:0] a, input logic [15:0] d);
        cli_we[i] = we;
        cli_addr[i*16 +: 16] = a;
        cli_wdata[i*16 +: 16] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Memory responder backed by mem_model; 'got' is low if mem_req never appeared.
    task automatic serve_access(output bit got);
        got = 1'b0;
        for (int c = 0; c < 20 && !mem_req; c++) tick();
        if (mem_req) begin
            got = 1'b1;
            if (mem_we) mem_model[mem_addr] = mem_wdata;
            else mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 16'h0000;
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [72:0] outs;
        do_reset();
        outs = {mem_req, busy, cli_ack, cli_err, grant_id, mem_we, mem_addr, mem_wdata, cli_rdata};
        n_checks++;
        if (outs !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", outs);
        end
    endtask

    task automatic test_single_read();
        set_client(0, 1'b0, 16'h0041, 16'h0000);
        cli_req = 4'b0001;
        tick();
        n_checks++;
        if ({mem_req, mem_we, mem_addr, grant_id, busy} !== {1'b1, 1'b0, 16'h0041, 2'd0, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL read_issue: req=%b we=%b addr=%h gid=%0d busy=%b expected 1 0 0041 0 1",
                     mem_req, mem_we, mem_addr, grant_id, busy);
        end
        tick();
        tick();
        n_checks++;
        if ({mem_req, cli_ack} !== {1'b1, 4'b0000}) begin
            n_fail++;
            $display("[TB] FAIL read_wait: req=%b ack=%b expected 1 0000", mem_req, cli_ack);
        end
        mem_ack = 1'b1;
        mem_rdata = 16'hAB45;
        tick();
        mem_ack = 1'b0;
        mem_rdata = 16'h0000;
        cli_req = 4'b0000;
        n_checks++;
        if ({cli_ack, cli_rdata, mem_req} !== {4'b0001, 16'hAB45, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL read_ack: ack=%b rdata=%h req=%b expected 0001 ab45 0", cli_ack, cli_rdata, mem_req);
        end
        tick();
        n_checks++;
        if ({cli_ack, busy} !== {4'b0000, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL read_ack_pulse: ack=%b busy=%b expected 0000 0", cli_ack, busy);
        end
    endtask

    task automatic test_all_writes();
        logic [15:0] wa [4] = '{16'h0000, 16'h0040, 16'h0080, 16'h00C0};
        logic [15:0] wd [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        do_reset();
        for (int i = 0; i < 4; i++) set_client(i, 1'b1, wa[i], wd[i]);
        cli_req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if ({grant_id, mem_req, mem_we, mem_addr, mem_wdata} !== {2'(k), 1'b1, 1'b1, wa[k], wd[k]}) begin
                n_fail++;
                $display("[TB] FAIL write_grant[%0d]: gid=%0d req=%b we=%b addr=%h wdata=%h expected %0d 1 1 %h %h",
                         k, grant_id, mem_req, mem_we, mem_addr, mem_wdata, k, wa[k], wd[k]);
            end
            mem_ack = 1'b1;
            mem_rdata = 16'hDEAD;
            tick();
            mem_ack = 1'b0;
            cli_req[k] = 1'b0;
            n_checks++;
            if (cli_ack !== 4'(1 << k)) begin
                n_fail++;
                $display("[TB] FAIL write_ack[%0d]: got %b expected %b", k, cli_ack, 4'(1 << k));
            end
            tick();
            n_checks++;
            if ({cli_ack, busy} !== {4'b0000, 1'b0}) begin
                n_fail++;
                $display("[TB] FAIL write_gap[%0d]: ack=%b busy=%b expected 0000 0", k, cli_ack, busy);
            end
        end
        mem_rdata = 16'h0000;
        n_checks++;
        if (cli_rdata !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL write_keeps_rdata: got %h expected 0000", cli_rdata);
        end
    endtask

    task automatic test_fairness();
        int exp_gid [6] = '{0, 1, 2, 0, 1, 2};
        for (int i = 0; i < 3; i++) set_client(i, 1'b0, 16'h0100 + 16'(i), 16'h0000);
        cli_req = 4'b0111;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_checks++;
            if (grant_id !== 2'(exp_gid[k])) begin
                n_fail++;
                $display("[TB] FAIL fair_order[%0d]: got %0d expected %0d", k, grant_id, exp_gid[k]);
            end
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            n_checks++;
            if (cli_ack !== 4'(1 << exp_gid[k])) begin
                n_fail++;
                $display("[TB] FAIL fair_ack[%0d]: got %b expected %b", k, cli_ack, 4'(1 << exp_gid[k]));
            end
            if (k == 5) cli_req = 4'b0000;
            tick();
        end
    endtask

    task automatic test_reset_mid_access();
        set_client(1, 1'b0, 16'h0200, 16'h0000);
        cli_req = 4'b0010;
        tick();
        n_checks++;
        if ({mem_req, grant_id} !== {1'b1, 2'd1}) begin
            n_fail++;
            $display("[TB] FAIL rst_mid_start: req=%b gid=%0d expected 1 1", mem_req, grant_id);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cli_req = 4'b0000;
        n_checks++;
        if ({mem_req, busy, cli_ack, cli_err} !== 10'b0) begin
            n_fail++;
            $display("[TB] FAIL rst_mid_abort: req=%b busy=%b ack=%b err=%b expected all 0",
                     mem_req, busy, cli_ack, cli_err);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        n_checks++;
        if ({mem_req, busy, cli_ack, cli_err} !== 10'b0) begin
            n_fail++;
            $display("[TB] FAIL rst_late_ack: req=%b busy=%b ack=%b err=%b expected all 0",
                     mem_req, busy, cli_ack, cli_err);
        end
        tick();
        n_checks++;
        if ({busy, cli_ack} !== 5'b0) begin
            n_fail++;
            $display("[TB] FAIL rst_late_ack_idle: busy=%b ack=%b expected 0 0000", busy, cli_ack);
        end
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int req_cycles = 0;
        do_reset();
        set_client(0, 1'b0, 16'h0300, 16'h0000);
        set_client(2, 1'b0, 16'h0302, 16'h0000);
        cli_req = 4'b0101;
        tick();
        for (int c = 0; c < 20 && mem_req; c++) begin
            req_cycles++;
            tick();
        end
        n_checks++;
        if (req_cycles !== 8) begin
            n_fail++;
            $display("[TB] FAIL timeout_len: got %0d cycles expected 8", req_cycles);
        end
        n_checks++;
        if ({cli_err, cli_ack} !== {4'b0001, 4'b0000}) begin
            n_fail++;
            $display("[TB] FAIL timeout_err: err=%b ack=%b expected 0001 0000", cli_err, cli_ack);
        end
        cli_req[0] = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({grant_id, mem_req} !== {2'd2, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL timeout_next: gid=%0d req=%b expected 2 1", grant_id, mem_req);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        cli_req = 4'b0000;
        n_checks++;
        if ({cli_ack, cli_err} !== {4'b0100, 4'b0000}) begin
            n_fail++;
            $display("[TB] FAIL timeout_next_ack: ack=%b err=%b expected 0100 0000", cli_ack, cli_err);
        end
        tick();
    endtask
`endif

    task automatic test_write_read();
        bit got;
        set_client(1, 1'b1, 16'h0123, 16'hFFA1);
        cli_req = 4'b0010;
        serve_access(got);
        cli_req = 4'b0000;
        n_checks++;
        if ({got, cli_ack, grant_id} !== {1'b1, 4'b0010, 2'd1}) begin
            n_fail++;
            $display("[TB] FAIL wr_phase: seen=%b ack=%b gid=%0d expected 1 0010 1", got, cli_ack, grant_id);
        end
        tick();
        set_client(3, 1'b0, 16'h0123, 16'h0000);
        cli_req = 4'b1000;
        serve_access(got);
        cli_req = 4'b0000;
        mem_rdata = 16'h0000;
        n_checks++;
        if ({got, cli_ack, grant_id, cli_rdata} !== {1'b1, 4'b1000, 2'd3, 16'hFFA1}) begin
            n_fail++;
            $display("[TB] FAIL rd_phase: seen=%b ack=%b gid=%0d rdata=%h expected 1 1000 3 ffa1",
                     got, cli_ack, grant_id, cli_rdata);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_all_writes();
        test_fairness();
        test_reset_mid_access();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_write_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
